// File: rtl/vga_timing_if.sv
// Bundle of timing outputs (plus pixel strobe) between the VGA timing core and the pixel pipeline.
// Latency: n/a (wiring only); VGA_LINE_MATCH_EN adds the line_match/line_irq pair.
// Backpressure: none; the timing source free-runs on clk_en, consumers must keep up.
interface vga_timing_if #(
  parameter int CW   = 10,
  parameter int FC_W = 8
);
  logic            clk_en;
  logic [CW-1:0]   hpos;
  logic [CW-1:0]   vpos;
  logic [CW-1:0]   hpos_s;
  logic [CW-1:0]   vpos_s;
  logic            active;
  logic            hsync;
  logic            vsync;
  logic            line_start;
  logic            frame_start;
  logic [FC_W-1:0] frame_count;
`ifdef VGA_LINE_MATCH_EN
  logic [CW-1:0]   line_match;
  logic            line_irq;

  modport master (
    input  clk_en, line_match,
    output hpos, vpos, hpos_s, vpos_s, active, hsync, vsync,
           line_start, frame_start, frame_count, line_irq
  );
  modport slave (
    output clk_en, line_match,
    input  hpos, vpos, hpos_s, vpos_s, active, hsync, vsync,
           line_start, frame_start, frame_count, line_irq
  );
`else
  modport master (
    input  clk_en,
    output hpos, vpos, hpos_s, vpos_s, active, hsync, vsync,
           line_start, frame_start, frame_count
  );
  modport slave (
    output clk_en,
    input  hpos, vpos, hpos_s, vpos_s, active, hsync, vsync,
           line_start, frame_start, frame_count
  );
`endif
endinterface

// File: rtl/vga_timing_pipe.sv
// VGA sync/timing generator with polarity control, SYNC_DELAY-stage flag pipeline, scaled coords and frame counter.
// Latency: positions undelayed; active/hsync/vsync/line_start/frame_start lag the counters by SYNC_DELAY clk_en beats.
// Backpressure: none; all state (counters and pipeline) freezes while clk_en=0. Optional feature: VGA_LINE_MATCH_EN.
module vga_timing_pipe #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK_PORCH  = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK_PORCH  = 33,
  parameter bit HSYNC_POL     = 1'b0,
  parameter bit VSYNC_POL     = 1'b0,
  parameter int SYNC_DELAY    = 0,
  parameter int SCALE_LOG2    = 0,
  parameter int CW            = 10,
  parameter int FC_W          = 8
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master tim
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FRONT_PORCH);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FRONT_PORCH + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FRONT_PORCH);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FRONT_PORCH + V_SYNC);

  if (H_TOTAL >= (1 << CW)) begin : g_h_chk
    $error("vga_timing_pipe: H_TOTAL does not fit in CW bits");
  end
  if (V_TOTAL >= (1 << CW)) begin : g_v_chk
    $error("vga_timing_pipe: V_TOTAL does not fit in CW bits");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 8) begin : g_d_chk
    $error("vga_timing_pipe: SYNC_DELAY must be 0..8");
  end

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
  } flags_t;

  logic [CW-1:0]   h;
  logic [CW-1:0]   v;
  logic [FC_W-1:0] fc;
  flags_t          raw;
  flags_t          dly;

  // Raster counters: h wraps per line, v per frame; frame_count bumps on the same beat as the (0,0) wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h  <= '0;
      v  <= '0;
      fc <= '0;
    end else if (tim.clk_en) begin
      if (h == H_LAST) begin
        h <= '0;
        if (v == V_LAST) begin
          v  <= '0;
          fc <= fc + 1'b1;
        end else begin
          v <= v + 1'b1;
        end
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  // Undelayed raster flags; vsync changes with v, i.e. at h=0.
  always_comb begin
    raw     = '0;
    raw.act = (h < H_ACT) && (v < V_ACT);
    raw.hs  = (h >= HS_START) && (h < HS_END);
    raw.vs  = (v >= VS_START) && (v < VS_END);
    raw.ls  = (h == '0);
    raw.fs  = (h == '0) && (v == '0);
  end

  if (SYNC_DELAY == 0) begin : g_nodly
    assign dly = raw;
  end else begin : g_pipe
    flags_t stage [SYNC_DELAY];

    // Flag shift register, advancing one stage per pixel strobe; resets to all-inactive.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < SYNC_DELAY; i++) stage[i] <= '0;
      end else if (tim.clk_en) begin
        stage[0] <= raw;
        for (int i = 1; i < SYNC_DELAY; i++) stage[i] <= stage[i-1];
      end
    end

    assign dly = stage[SYNC_DELAY-1];
  end

  // Outputs are forced inactive while rst is high (matters when SYNC_DELAY=0 and (0,0) would otherwise show).
  // Pulses are gated by clk_en so they last one clk even with a multi-cycle strobe.
  assign tim.hpos        = h;
  assign tim.vpos        = v;
  assign tim.hpos_s      = h >> SCALE_LOG2;
  assign tim.vpos_s      = v >> SCALE_LOG2;
  assign tim.frame_count = fc;
  assign tim.active      = dly.act & ~rst;
  assign tim.hsync       = (dly.hs & ~rst) ? HSYNC_POL : ~HSYNC_POL;
  assign tim.vsync       = (dly.vs & ~rst) ? VSYNC_POL : ~VSYNC_POL;
  assign tim.line_start  = dly.ls & tim.clk_en & ~rst;
  assign tim.frame_start = dly.fs & tim.clk_en & ~rst;

`ifdef VGA_LINE_MATCH_EN
  // Start-of-hblank interrupt on the selected line; out-of-range line_match simply never equals v.
  assign tim.line_irq = tim.clk_en & ~rst & (h == H_ACT) & (v == tim.line_match);
`endif

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Randomised bench for vga_timing_pipe in small raster mode (16x10), two instances:
// u_dut0 plain (no delay, active-low syncs), u_dut1 SYNC_DELAY=2, active-high syncs, SCALE_LOG2=1.
// Expected values come from the count of enabled beats since reset, mapped to raster positions arithmetically.
module tb_vga_timing_pipe;

  localparam int HT = 16;
  localparam int VT = 10;

  logic       clk;
  logic       rst;
  logic       clk_en;
  logic [9:0] lm;

  int checks = 0;
  int errors = 0;
  int n      = 0;   // enabled beats since last reset

  vga_timing_if #(.CW(10), .FC_W(8)) vif0 ();
  vga_timing_if #(.CW(10), .FC_W(8)) vif1 ();

  assign vif0.clk_en = clk_en;
  assign vif1.clk_en = clk_en;
`ifdef VGA_LINE_MATCH_EN
  assign vif0.line_match = lm;
  assign vif1.line_match = lm;
`endif

  vga_timing_pipe #(
    .H_ACTIVE(8), .H_FRONT_PORCH(2), .H_SYNC(4), .H_BACK_PORCH(2),
    .V_ACTIVE(6), .V_FRONT_PORCH(1), .V_SYNC(2), .V_BACK_PORCH(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .SYNC_DELAY(0), .SCALE_LOG2(0),
    .CW(10), .FC_W(8)
  ) u_dut0 (
    .clk (clk),
    .rst (rst),
    .tim (vif0)
  );

  vga_timing_pipe #(
    .H_ACTIVE(8), .H_FRONT_PORCH(2), .H_SYNC(4), .H_BACK_PORCH(2),
    .V_ACTIVE(6), .V_FRONT_PORCH(1), .V_SYNC(2), .V_BACK_PORCH(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .SYNC_DELAY(2), .SCALE_LOG2(1),
    .CW(10), .FC_W(8)
  ) u_dut1 (
    .clk (clk),
    .rst (rst),
    .tim (vif1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d (t=%0t n=%0d)", tag, obs, exp, $time, n);
    end
  endtask

  // Flags {act,hs,vs,ls,fs} of the raster position reached after m beats; before the first beat: inactive.
  function automatic logic [4:0] flags(input int m);
    int x, y;
    if (m < 0) return 5'b0;
    x = m % HT;
    y = (m / HT) % VT;
    return {x < 8 && y < 6, x >= 10 && x < 14, y >= 7 && y < 9, x == 0, x == 0 && y == 0};
  endfunction

  task automatic check_all();
    int x, y, fc;
    logic [4:0] f0, f1;
    logic e;
    x  = n % HT;
    y  = (n / HT) % VT;
    fc = (n / (HT * VT)) % 256;
    f0 = flags(n);
    f1 = flags(n - 2);
    e  = clk_en && !rst;

    chk("d0_hpos",  32'(vif0.hpos),  32'(x));
    chk("d0_vpos",  32'(vif0.vpos),  32'(y));
    chk("d0_hpos_s", 32'(vif0.hpos_s), 32'(x));
    chk("d0_fcount", 32'(vif0.frame_count), 32'(fc));
    chk("d0_active", 32'(vif0.active), 32'(!rst && f0[4]));
    chk("d0_hsync", 32'(vif0.hsync), 32'((!rst && f0[3]) ? 1'b0 : 1'b1));
    chk("d0_vsync", 32'(vif0.vsync), 32'((!rst && f0[2]) ? 1'b0 : 1'b1));
    chk("d0_lstart", 32'(vif0.line_start), 32'(e && f0[1]));
    chk("d0_fstart", 32'(vif0.frame_start), 32'(e && f0[0]));

    chk("d1_hpos",  32'(vif1.hpos),  32'(x));
    chk("d1_vpos",  32'(vif1.vpos),  32'(y));
    chk("d1_hpos_s", 32'(vif1.hpos_s), 32'(x / 2));
    chk("d1_vpos_s", 32'(vif1.vpos_s), 32'(y / 2));
    chk("d1_fcount", 32'(vif1.frame_count), 32'(fc));
    chk("d1_active", 32'(vif1.active), 32'(!rst && f1[4]));
    chk("d1_hsync", 32'(vif1.hsync), 32'((!rst && f1[3]) ? 1'b1 : 1'b0));
    chk("d1_vsync", 32'(vif1.vsync), 32'((!rst && f1[2]) ? 1'b1 : 1'b0));
    chk("d1_lstart", 32'(vif1.line_start), 32'(e && f1[1]));
    chk("d1_fstart", 32'(vif1.frame_start), 32'(e && f1[0]));
`ifdef VGA_LINE_MATCH_EN
    chk("d0_line_irq", 32'(vif0.line_irq), 32'(e && x == 8 && 32'(y) == 32'(lm)));
    chk("d1_line_irq", 32'(vif1.line_irq), 32'(e && x == 8 && 32'(y) == 32'(lm)));
`endif
  endtask

  // One clock: check mid-cycle, account for the edge, then present the next inputs just after it.
  task automatic cyc(input logic en_next, input logic rst_next);
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (!rst && clk_en) n++;
    #1;
    clk_en = en_next;
    rst    = rst_next;
    if (rst) n = 0;
  endtask

  initial begin
    int guard;
    rst    = 1'b1;
    clk_en = 1'b1;
    lm     = 10'd3;
    n      = 0;

    // 100 ns of reset with the strobe running: outputs must stay at reset values.
    repeat (10) cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);

    // Continuous strobe: more than one frame, frame_count reaches 1.
    repeat (200) cyc(1'b1, 1'b0);

    // Strobe every other clock: pulses still one clk wide, outputs hold in the gaps.
    for (int i = 0; i < 200; i++) cyc(i[0], 1'b0);

    // Run to (h=5, v=3) of the current frame, then reset asynchronously mid-cycle.
    guard = 0;
    while ((n % (HT * VT)) != 53 && guard < 400) begin
      cyc(1'b1, 1'b0);
      guard++;
    end
    @(negedge clk);
    chk("pre_rst_hpos", 32'(vif0.hpos), 32'd5);
    chk("pre_rst_vpos", 32'(vif0.vpos), 32'd3);
    #2;
    rst = 1'b1;
    n   = 0;
    #1;
    check_all();
    repeat (3) cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);

    // Random strobe and random line_match (including out-of-range values).
    for (int i = 0; i < 700; i++) begin
      if (i % 100 == 0) begin
        case ($urandom_range(0, 2))
          0:       lm = 10'd3;
          1:       lm = 10'd12;
          default: lm = 10'($urandom_range(0, 9));
        endcase
      end
      cyc($urandom_range(0, 3) != 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
